gpio_ctrl: RTL

- Parametrised GPIO controller, successor to the fixed 4x8-bit GPIO on the peripheral bus.
- Provides NPORTS 8-bit ports, atomic set/clear/toggle of outputs and per-pin edge or level interrupts.
- Adds a readable, write-1-to-clear per-pin interrupt status register, plus an optional input glitch filter.
- Sits on the same word-addressed enable/ready peripheral bus; per-port interrupt lines go to the interrupt controller.

---
 rtl/gpio_ctrl_pkg.sv | 18 +
 rtl/gpio_filter.sv | 27 ++
 rtl/gpio_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg: register word indices, port width and filter counter sizing for gpio_ctrl
package gpio_ctrl_pkg;
  localparam logic [3:0] IDX_PD   = 4'd0;
  localparam logic [3:0] IDX_DD   = 4'd1;
  localparam logic [3:0] IDX_IE   = 4'd2;
  localparam logic [3:0] IDX_EP   = 4'd3;
  localparam logic [3:0] IDX_IS   = 4'd4;
  localparam logic [3:0] IDX_OS   = 4'd5;
  localparam logic [3:0] IDX_OC   = 4'd6;
  localparam logic [3:0] IDX_OT   = 4'd7;
  localparam logic [3:0] IDX_IM   = 4'd8;
  localparam logic [3:0] IDX_INFO = 4'd9;
  localparam logic [3:0] IDX_LAST = 4'd9;
  localparam int PORT_W = 8;
  function automatic int cnt_w(input int fc);
    return $clog2(fc + 1);
  endfunction
endpackage

// File: rtl/gpio_filter.sv
// gpio_filter: single-pin glitch filter; q follows d only after d differs for FILTER_CYCLES cycles
module gpio_filter
  import gpio_ctrl_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  localparam int CW = cnt_w(FILTER_CYCLES);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (d == q) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
      cnt <= '0;
      q   <= d;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: NPORTS x 8-bit GPIO with set/clear/toggle, edge/level interrupts and W1C status.
// Optional input glitch filter enabled by defining GPIO_CTRL_FILTER_EN.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int NPORTS        = 4,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORT_W*NPORTS-1:0]   gpio_i,
  input  logic [31:0]                gpio_address,
  input  logic [31:0]                gpio_data_i,
  input  logic [3:0]                 gpio_wr,
  input  logic                       gpio_enable,
  output logic [PORT_W*NPORTS-1:0]   gpio_o,
  output logic [PORT_W*NPORTS-1:0]   gpio_oe,
  output logic [31:0]                gpio_data_o,
  output logic                       gpio_ready,
  output logic [NPORTS-1:0]          gpio_interrupt
);
  localparam int W = PORT_W * NPORTS;
`ifdef GPIO_CTRL_FILTER_EN
  localparam logic [7:0] FC_INFO = 8'(FILTER_CYCLES);
`else
  localparam logic [7:0] FC_INFO = 8'd0;
`endif
  logic [W-1:0] s1, in_s, in_f, in_d;
  logic [W-1:0] ie, ep, is, im;
  logic [W-1:0] wm, wd, wdm, ev, set, rd_w;
  logic [NPORTS-1:0] irq_n;
  logic [3:0] idx;
  logic op, do_op;
  logic [31:0] rdata;
  logic unused;
  assign unused = ^{gpio_address[31:6], gpio_address[1:0], gpio_data_i, gpio_wr};
  assign idx   = gpio_address[5:2];
  assign op    = gpio_enable & ~gpio_ready;
  assign do_op = op & (idx <= IDX_LAST);
  assign wd    = gpio_data_i[W-1:0];
  assign wdm   = wd & wm;
`ifdef GPIO_CTRL_FILTER_EN
  for (genvar g = 0; g < W; g++) begin : g_filt
    gpio_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt (
      .clk (clk),
      .rst (rst),
      .d   (in_s[g]),
      .q   (in_f[g])
    );
  end
`else
  assign in_f = in_s;
`endif
  // Edge mode picks rising or falling by EP; level mode fires while input equals EP
  assign ev  = (im & ~(in_f ^ ep)) | (~im & ((ep & in_f & ~in_d) | (~ep & ~in_f & in_d)));
  assign set = ie & ~gpio_oe & ev;
  always_comb begin
    wm    = '0;
    irq_n = '0;
    for (int p = 0; p < NPORTS; p++) begin
      wm[PORT_W*p +: PORT_W] = {PORT_W{gpio_wr[p]}};
      irq_n[p] = |(is[PORT_W*p +: PORT_W] & ie[PORT_W*p +: PORT_W]);
    end
  end
  always_comb begin
    rd_w  = idx == IDX_PD ? in_f :
            idx == IDX_DD ? gpio_oe :
            idx == IDX_IE ? ie :
            idx == IDX_EP ? ep :
            idx == IDX_IS ? is :
            idx == IDX_IM ? im : '0;
    rdata = idx == IDX_INFO ? {16'd0, FC_INFO, 8'(NPORTS)} : 32'(rd_w);
  end
  function automatic logic sel(input logic [3:0] i);
    return do_op && idx == i;
  endfunction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1             <= '0;
      in_s           <= '0;
      in_d           <= '0;
      gpio_o         <= '0;
      gpio_oe        <= '0;
      ie             <= '0;
      ep             <= '0;
      is             <= '0;
      im             <= '0;
      gpio_data_o    <= '0;
      gpio_ready     <= 1'b0;
      gpio_interrupt <= '0;
    end else begin
      s1             <= gpio_i;
      in_s           <= s1;
      in_d           <= in_f;
      gpio_ready     <= do_op;
      gpio_data_o    <= do_op ? rdata : gpio_data_o;
      gpio_o         <= sel(IDX_PD) ? (gpio_o & ~wm) | wdm :
                        sel(IDX_OS) ? gpio_o | wdm :
                        sel(IDX_OC) ? gpio_o & ~wdm :
                        sel(IDX_OT) ? gpio_o ^ wdm : gpio_o;
      gpio_oe        <= sel(IDX_DD) ? (gpio_oe & ~wm) | wdm : gpio_oe;
      ie             <= sel(IDX_IE) ? (ie & ~wm) | wdm : ie;
      ep             <= sel(IDX_EP) ? (ep & ~wm) | wdm : ep;
      im             <= sel(IDX_IM) ? (im & ~wm) | wdm : im;
      is             <= (is & ~(sel(IDX_IS) ? wdm : '0)) | set;
      gpio_interrupt <= irq_n;
    end
  end
endmodule
